// File: rtl/relprime_top_level.sv
// relprime_top_level
//   Computes relPrime(n): the smallest m >= 2 with gcd(n, m) == 1 for an
//   unsigned WIDTH-bit n. On a start request, n is latched and a search over
//   candidate m values begins. Each candidate is tested with a
//   subtraction-based Euclid GCD that performs one step per clock.
//
// Ports
//   CLK             system clock; all state updates on the rising edge
//   RST_N           asynchronous, active-low reset
//   register_value  n; sampled only when a computation is accepted
//   decimal_two     first candidate m (normally 2)
//   decimal_one     candidate increment (normally 1)
//   start           level-sampled request while idle or done
//   out             last result m; held until the next success or reset
//   done            high while the result on out is valid
module relprime_top_level #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] register_value,
  input  logic [WIDTH-1:0] decimal_two,
  input  logic [WIDTH-1:0] decimal_one,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GCD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;

  // State and datapath registers; reset returns the block to idle with all
  // operands and the result cleared.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
    end
  end

  // Next-state and datapath control. Every register holds by default and only
  // the state currently active changes it.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d = register_value;
          m_d = decimal_two;
          // n = 0 has no coprime m (gcd(0, m) = m), so it short-circuits to a
          // zero result instead of searching forever.
          if (register_value == '0) begin
            out_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        a_d     = n_q;
        b_d     = m_q;
        state_d = S_GCD;
      end

      // Always subtract the smaller operand from the larger, so nothing
      // underflows; equality means a_q holds the GCD.
      S_GCD: begin
        if (a_q == b_q) begin
          state_d = S_CHECK;
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
      end

      S_CHECK: begin
        if (a_q == WIDTH'(1)) begin
          out_d   = m_q;
          state_d = S_DONE;
        end else begin
          m_d     = m_q + decimal_one;
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out  = out_q;
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_relprime_top_level.sv
// tb_relprime_top_level
//   Directed-vector bench for relprime_top_level. Each task drives one
//   scenario and compares the outputs against hand-computed values.
module tb_relprime_top_level;

  localparam int WIDTH  = 16;
  localparam int BUDGET = 200000;

  logic             CLK;
  logic             RST_N;
  logic [WIDTH-1:0] register_value;
  logic [WIDTH-1:0] decimal_two;
  logic [WIDTH-1:0] decimal_one;
  logic             start;
  logic [WIDTH-1:0] out;
  logic             done;

  int errors = 0;
  int checks = 0;

  relprime_top_level #(.WIDTH(WIDTH)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .register_value (register_value),
    .decimal_two    (decimal_two),
    .decimal_one    (decimal_one),
    .start          (start),
    .out            (out),
    .done           (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive a one-cycle start pulse aligned to the falling edge.
  task automatic pulse_start(input logic [WIDTH-1:0] n);
    @(negedge CLK);
    register_value = n;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; a timeout counts as a failed check.
  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < BUDGET) begin
      @(negedge CLK);
      cyc++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: done=%b after %0d cycles, expected 1", name, done, cyc);
    end
  endtask

  task automatic check_out(input string name, input logic [WIDTH-1:0] exp);
    checks++;
    if (out !== exp) begin
      errors++;
      $display("[TB] FAIL %s: out=%0d expected %0d", name, out, exp);
    end
  endtask

  task automatic check_done(input string name, input logic exp);
    checks++;
    if (done !== exp) begin
      errors++;
      $display("[TB] FAIL %s: done=%b expected %b", name, done, exp);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    start = 1'b0;
    register_value = '0;
    decimal_two = 16'd2;
    decimal_one = 16'd1;
    repeat (3) @(negedge CLK);
    check_out("reset_out", '0);
    check_done("reset_done", 1'b0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check_done("idle_done", 1'b0);
  endtask

  task automatic test_primorial();
    pulse_start(16'd30030);
    wait_done("n30030");
    check_out("n30030_out", 16'd17);
    pulse_start(16'd6);
    check_done("restart_done_drop", 1'b0);
    check_out("restart_out_held", 16'd17);
    wait_done("n6");
    check_out("n6_out", 16'd5);
  endtask

  task automatic test_zero();
    int cyc;
    pulse_start(16'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2) begin
      @(negedge CLK);
      cyc++;
    end
    check_done("n0_done", 1'b1);
    check_out("n0_out", 16'd0);
  endtask

  task automatic test_boundary();
    pulse_start(16'd1);
    wait_done("n1");
    check_out("n1_out", 16'd2);
    pulse_start(16'd65535);
    wait_done("n65535");
    check_out("n65535_out", 16'd2);
  endtask

  task automatic test_reset_mid();
    pulse_start(16'd36432);
    repeat (100) @(negedge CLK);
    check_done("mid_busy_done", 1'b0);
    check_out("mid_out_held", 16'd2);
    #2 RST_N = 1'b0;
    #1;
    check_out("async_reset_out", '0);
    check_done("async_reset_done", 1'b0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    pulse_start(16'd36432);
    repeat (5) @(negedge CLK);
    register_value = 16'd7;
    wait_done("n36432");
    check_out("n36432_out", 16'd5);
  endtask

  task automatic test_back_to_back();
    int   rises;
    int   doubles;
    logic prev;
    rises = 0;
    doubles = 0;
    @(negedge CLK);
    prev = done;
    register_value = 16'd6;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (done === 1'b1 && prev === 1'b0) rises++;
      if (done === 1'b1 && prev === 1'b1) doubles++;
      if (done === 1'b1) check_out("held_out", 16'd5);
      prev = done;
    end
    start = 1'b0;
    checks++;
    if (rises < 3) begin
      errors++;
      $display("[TB] FAIL held_rises: done rises=%0d expected >= 3", rises);
    end
    checks++;
    if (doubles != 0) begin
      errors++;
      $display("[TB] FAIL held_pulse: done double-high samples=%0d expected 0", doubles);
    end
    wait_done("held_final");
    check_out("held_final_out", 16'd5);
  endtask

  initial begin
    test_reset();
    test_primorial();
    test_zero();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
